// File: rtl/key_core_word_pkg.sv
// Shared definitions for the key-schedule core word: Rcon constants, FSM states, xtime helper.
package key_core_word_pkg;

    localparam logic [7:0]  RCON_INIT  = 8'h01;
    localparam logic [7:0]  RCON_POLY  = 8'h1B;
    localparam int unsigned NR_DEFAULT = 10;

    typedef enum logic [2:0] {
        StIdle,
        StSub0,
        StSub1,
        StSub2,
        StSub3
    } state_e;

    // Multiply by x in GF(2^8); shared with MixColumns.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box lookup, shared with the SubBytes stage.
module aes_sbox (
    input  logic [7:0] plain,
    output logic [7:0] subst
);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
        8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
        8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
        8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
        8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
        8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
        8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
        8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
        8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
        8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
        8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
        8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
        8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
        8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
        8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
        8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
        8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign subst = SBOX[plain];

endmodule

// File: rtl/key_core_word.sv
// Core word SubWord(RotWord(w3)) ^ Rcon with round counter and Rcon generator.
// Build option KEY_CORE_PARALLEL_SBOX_EN: four S-boxes, single-cycle result.
module key_core_word
    import key_core_word_pkg::*;
#(
    parameter int unsigned NR = NR_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         init,
    input  logic         start,
    input  logic [127:0] key,
    output logic [31:0]  s_boxed_row,
    output logic         valid,
    output logic         busy,
    output logic [3:0]   rnd
);

    localparam logic [3:0] LAST_RND = 4'(NR - 1);

    state_e      state_q, state_d;
    logic [31:0] rot_q, rot_d;
    logic [7:0]  rcon_q, rcon_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] word_q, word_d;
    logic        valid_q, valid_d;
    logic [3:0]  rnd_q, rnd_d;
    logic [31:0] sub_full;

    // Only column 3 of the key feeds the core word.
    logic unused_key_bits;
    assign unused_key_bits = ^{key[119:96], key[87:64], key[55:32], key[23:0]};

`ifdef KEY_CORE_PARALLEL_SBOX_EN
    for (genvar i = 0; i < 4; i++) begin : g_sbox
        aes_sbox u_sbox (
            .plain (rot_q[8*i +: 8]),
            .subst (sub_full[8*i +: 8])
        );
    end
`else
    logic [7:0]  sbox_in, sbox_out;
    logic [23:0] hold_q, hold_d;

    always_comb begin
        sbox_in = rot_q[7:0];
        unique case (state_q)
            StSub1:  sbox_in = rot_q[15:8];
            StSub2:  sbox_in = rot_q[23:16];
            StSub3:  sbox_in = rot_q[31:24];
            default: sbox_in = rot_q[7:0];
        endcase
    end

    aes_sbox u_sbox (
        .plain (sbox_in),
        .subst (sbox_out)
    );

    always_comb begin
        hold_d = hold_q;
        unique case (state_q)
            StSub0:  hold_d[7:0]   = sbox_out;
            StSub1:  hold_d[15:8]  = sbox_out;
            StSub2:  hold_d[23:16] = sbox_out;
            default: hold_d = hold_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end

    assign sub_full = {sbox_out, hold_q};
`endif

    always_comb begin
        state_d = state_q;
        rot_d   = rot_q;
        rcon_d  = rcon_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        valid_d = valid_q;
        rnd_d   = rnd_q;

        if (init) begin
            state_d = StIdle;
            valid_d = 1'b0;
            cnt_d   = '0;
            rcon_d  = RCON_INIT;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_d = StSub0;
                        valid_d = 1'b0;
                        // RotWord of column 3: rows 0..3 = byte7, byte11, byte15, byte3
                        rot_d   = {key[31:24], key[127:120], key[95:88], key[63:56]};
                    end
                end
`ifndef KEY_CORE_PARALLEL_SBOX_EN
                StSub0: state_d = StSub1;
                StSub1: state_d = StSub2;
                StSub2: state_d = StSub3;
                StSub3: begin
`else
                StSub0: begin
`endif
                    state_d = StIdle;
                    word_d  = sub_full ^ {24'h0, rcon_q};
                    valid_d = 1'b1;
                    rnd_d   = cnt_q;
                    cnt_d   = (cnt_q == LAST_RND) ? cnt_q : cnt_q + 4'd1;
                    rcon_d  = xtime(rcon_q);
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            rot_q   <= '0;
            rcon_q  <= RCON_INIT;
            cnt_q   <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
            rnd_q   <= '0;
        end else begin
            state_q <= state_d;
            rot_q   <= rot_d;
            rcon_q  <= rcon_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            valid_q <= valid_d;
            rnd_q   <= rnd_d;
        end
    end

    assign s_boxed_row = word_q;
    assign valid       = valid_q;
    assign busy        = (state_q != StIdle);
    assign rnd         = rnd_q;

endmodule
